// File: rtl/axi4_lite_mst.sv
// AXI4-Lite master with one transaction outstanding: it pulls a command from a FWFT FIFO,
// runs one AXI read or write, and pushes the response into a response FIFO.
module axi4_lite_mst #(
    parameter int g_axi_addr_width = 28
) (
    input  logic                         aclk_i,
    input  logic                         areset_n_i,
    input  logic                         cmd_empty_i,
    input  logic [g_axi_addr_width+36:0] cmd_data_i,
    output logic                         cmd_pull_o,
    input  logic                         rsp_full_i,
    output logic [34:0]                  rsp_data_o,
    output logic                         rsp_push_o,
    output logic                         awvalid_o,
    input  logic                         awready_i,
    output logic [g_axi_addr_width-1:0]  awaddr_o,
    output logic [2:0]                   awprot_o,
    output logic                         wvalid_o,
    input  logic                         wready_i,
    output logic [31:0]                  wdata_o,
    output logic [3:0]                   wstrb_o,
    input  logic                         bvalid_i,
    output logic                         bready_o,
    input  logic [1:0]                   bresp_i,
    output logic                         arvalid_o,
    input  logic                         arready_i,
    output logic [g_axi_addr_width-1:0]  araddr_o,
    output logic [2:0]                   arprot_o,
    input  logic                         rvalid_i,
    output logic                         rready_o,
    input  logic [31:0]                  rdata_i,
    input  logic [1:0]                   rresp_i,
    output logic                         busy_o
);

    localparam int AW = g_axi_addr_width;
    localparam int CW = AW + 37;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WR_REQ  = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_RESP = 3'd5,
        ST_PUSH    = 3'd6
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            aw_done_r;
    logic            aw_done_s;
    logic            w_done_r;
    logic            w_done_s;
    logic            hold_we_r;
    logic            hold_we_s;
    logic [AW-1:0]   hold_addr_r;
    logic [AW-1:0]   hold_addr_s;
    logic [31:0]     hold_wdata_r;
    logic [31:0]     hold_wdata_s;
    logic [3:0]      hold_wstrb_r;
    logic [3:0]      hold_wstrb_s;
    logic [34:0]     rsp_data_r;
    logic [34:0]     rsp_data_s;
    logic            cmd_pull_r;
    logic            cmd_pull_s;
    logic            rsp_push_r;
    logic            rsp_push_s;
    logic            awvalid_r;
    logic            awvalid_s;
    logic            wvalid_r;
    logic            wvalid_s;
    logic            bready_r;
    logic            bready_s;
    logic            arvalid_r;
    logic            arvalid_s;
    logic            rready_r;
    logic            rready_s;
    logic            busy_r;
    logic            busy_s;

    // Next state, per-channel handshake tracking, command latch and response capture
    always_comb begin
        state_s      = state_r;
        aw_done_s    = 1'b0;
        w_done_s     = 1'b0;
        hold_we_s    = hold_we_r;
        hold_addr_s  = hold_addr_r;
        hold_wdata_s = hold_wdata_r;
        hold_wstrb_s = hold_wstrb_r;
        rsp_data_s   = rsp_data_r;
        case (state_r)
            ST_IDLE: begin
                if (!cmd_empty_i) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                hold_we_s    = cmd_data_i[CW-1];
                hold_addr_s  = cmd_data_i[AW+35:36];
                hold_wdata_s = cmd_data_i[35:4];
                hold_wstrb_s = cmd_data_i[3:0];
                if (cmd_data_i[CW-1]) begin
                    state_s = ST_WR_REQ;
                end else begin
                    state_s = ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; leave only once both are done
                aw_done_s = aw_done_r | (awvalid_r & awready_i);
                w_done_s  = w_done_r | (wvalid_r & wready_i);
                if (aw_done_r && w_done_r) begin
                    state_s = ST_WR_RESP;
                end else begin
                    state_s = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (bready_r && bvalid_i) begin
                    rsp_data_s = {hold_we_r, 32'h0000_0000, bresp_i};
                    state_s    = ST_PUSH;
                end else begin
                    state_s = ST_WR_RESP;
                end
            end
            ST_RD_REQ: begin
                if (arvalid_r && arready_i) begin
                    state_s = ST_RD_RESP;
                end else begin
                    state_s = ST_RD_REQ;
                end
            end
            ST_RD_RESP: begin
                if (rready_r && rvalid_i) begin
                    rsp_data_s = {1'b0, rdata_i, rresp_i};
                    state_s    = ST_PUSH;
                end else begin
                    state_s = ST_RD_RESP;
                end
            end
            ST_PUSH: begin
                if (rsp_push_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PUSH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the next state so each output is a clean register.
    // The full flag only falls on its own, so sampling it one cycle early never overfills.
    always_comb begin
        cmd_pull_s = (state_s == ST_FETCH);
        awvalid_s  = (state_s == ST_WR_REQ) && !aw_done_s;
        wvalid_s   = (state_s == ST_WR_REQ) && !w_done_s;
        bready_s   = (state_s == ST_WR_RESP);
        arvalid_s  = (state_s == ST_RD_REQ);
        rready_s   = (state_s == ST_RD_RESP);
        rsp_push_s = (state_s == ST_PUSH) && !rsp_full_i;
        busy_s     = (state_s != ST_IDLE);
    end

    // State, holding and output registers
    always_ff @(posedge aclk_i or negedge areset_n_i) begin
        if (!areset_n_i) begin
            state_r      <= ST_IDLE;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
            hold_we_r    <= 1'b0;
            hold_addr_r  <= {AW{1'b0}};
            hold_wdata_r <= 32'h0000_0000;
            hold_wstrb_r <= 4'h0;
            rsp_data_r   <= 35'h0_0000_0000;
            cmd_pull_r   <= 1'b0;
            rsp_push_r   <= 1'b0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            aw_done_r    <= aw_done_s;
            w_done_r     <= w_done_s;
            hold_we_r    <= hold_we_s;
            hold_addr_r  <= hold_addr_s;
            hold_wdata_r <= hold_wdata_s;
            hold_wstrb_r <= hold_wstrb_s;
            rsp_data_r   <= rsp_data_s;
            cmd_pull_r   <= cmd_pull_s;
            rsp_push_r   <= rsp_push_s;
            awvalid_r    <= awvalid_s;
            wvalid_r     <= wvalid_s;
            bready_r     <= bready_s;
            arvalid_r    <= arvalid_s;
            rready_r     <= rready_s;
            busy_r       <= busy_s;
        end
    end

    assign cmd_pull_o = cmd_pull_r;
    assign rsp_push_o = rsp_push_r;
    assign rsp_data_o = rsp_data_r;
    assign awvalid_o  = awvalid_r;
    assign awaddr_o   = hold_addr_r;
    assign awprot_o   = 3'b000;
    assign wvalid_o   = wvalid_r;
    assign wdata_o    = hold_wdata_r;
    assign wstrb_o    = hold_wstrb_r;
    assign bready_o   = bready_r;
    assign arvalid_o  = arvalid_r;
    assign araddr_o   = hold_addr_r;
    assign arprot_o   = 3'b000;
    assign rready_o   = rready_r;
    assign busy_o     = busy_r;

endmodule

// File: tb/tb_axi4_lite_mst.sv
// Directed bench for axi4_lite_mst: a command FIFO, an AXI slave with programmable
// ready delays and a transaction-level scoreboard checked on every cycle.
module tb_axi4_lite_mst;

    localparam int AW = 28;

    logic             aclk_i = 1'b0;
    logic             areset_n_i;
    logic             cmd_empty_i;
    logic [AW+36:0]   cmd_data_i;
    logic             cmd_pull_o;
    logic             rsp_full_i;
    logic [34:0]      rsp_data_o;
    logic             rsp_push_o;
    logic             awvalid_o, awready_i, wvalid_o, wready_i;
    logic [AW-1:0]    awaddr_o, araddr_o;
    logic [2:0]       awprot_o, arprot_o;
    logic [31:0]      wdata_o, rdata_i;
    logic [3:0]       wstrb_o;
    logic             bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o, busy_o;
    logic [1:0]       bresp_i, rresp_i;

    always #5 aclk_i = ~aclk_i;

    axi4_lite_mst #(.g_axi_addr_width(AW)) dut (
        .aclk_i(aclk_i), .areset_n_i(areset_n_i),
        .cmd_empty_i(cmd_empty_i), .cmd_data_i(cmd_data_i), .cmd_pull_o(cmd_pull_o),
        .rsp_full_i(rsp_full_i), .rsp_data_o(rsp_data_o), .rsp_push_o(rsp_push_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awprot_o(awprot_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arprot_o(arprot_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: what the command stream says must appear on each channel
    logic [AW+36:0] cmd_q[$];
    logic [AW-1:0]  exp_aw_q[$];
    logic [AW-1:0]  exp_ar_q[$];
    logic [35:0]    exp_w_q[$];
    logic [34:0]    exp_rsp_q[$];
    logic [33:0]    slv_q[$];

    int  aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit  full_mode = 1'b0;
    int  aw_cnt, w_cnt, ar_cnt, full_cnt;
    bit  aw_hs_p, w_hs_p, ar_hs_p, b_hs_p, r_hs_p, pull_p, push_p;
    bit  slv_aw_done, slv_w_done, pend_b, pend_r, rsp_waiting;
    bit  txn_open, cur_we;
    bit  prev_awv, prev_wv, prev_arv, prev_aw_hs, prev_w_hs, prev_ar_hs;
    logic [AW-1:0] prev_awaddr, prev_araddr;
    logic [35:0]   prev_w;
    logic [34:0]   last_rsp;
    int  cyc = 0, pull_cyc = 0, push_cyc = 0, fall_cyc = 0, last_lat = 0;
    int  aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, push_n = 0, pull_n = 0, arv_cycles = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic issue(input bit we, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] resp, input logic [31:0] rd);
        cmd_q.push_back({we, a, d, s});
        if (we) begin
            exp_aw_q.push_back(a);
            exp_w_q.push_back({d, s});
            exp_rsp_q.push_back({1'b1, 32'h0000_0000, resp});
        end else begin
            exp_ar_q.push_back(a);
            exp_rsp_q.push_back({1'b0, rd, resp});
        end
        slv_q.push_back({rd, resp});
    endtask

    task automatic monitor();
        aw_hs_p = awvalid_o & awready_i;
        w_hs_p  = wvalid_o & wready_i;
        ar_hs_p = arvalid_o & arready_i;
        b_hs_p  = bvalid_i & bready_o;
        r_hs_p  = rvalid_i & rready_o;
        pull_p  = cmd_pull_o;
        push_p  = rsp_push_o;
        chk("busy", busy_o, cmd_pull_o | txn_open);
        chk("prot", {awprot_o, arprot_o}, 6'd0);
        if (txn_open) begin
            chk("no_pull_busy", cmd_pull_o, 1'b0);
            if (cur_we) chk("rd_chan_idle", {arvalid_o, rready_o}, 2'b00);
            else        chk("wr_chan_idle", {awvalid_o, wvalid_o, bready_o}, 3'b000);
        end else begin
            chk("all_idle", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_push_o}, 6'd0);
        end
        if (rsp_full_i) chk("no_push_full", rsp_push_o, 1'b0);
        if (prev_awv) chk("aw_hold", {awvalid_o, awaddr_o}, {1'b1, prev_awaddr});
        if (prev_wv)  chk("w_hold", {wvalid_o, wdata_o, wstrb_o}, {1'b1, prev_w});
        if (prev_arv) chk("ar_hold", {arvalid_o, araddr_o}, {1'b1, prev_araddr});
        if (prev_aw_hs) chk("aw_drop", awvalid_o, 1'b0);
        if (prev_w_hs)  chk("w_drop", wvalid_o, 1'b0);
        if (prev_ar_hs) chk("ar_drop", arvalid_o, 1'b0);
        if (arvalid_o) arv_cycles++;
        if (aw_hs_p) begin
            aw_hs_n++;
            if (exp_aw_q.size() > 0) chk("awaddr", awaddr_o, exp_aw_q.pop_front());
            else chk("aw_unexpected", aw_hs_p, 1'b0);
        end
        if (w_hs_p) begin
            w_hs_n++;
            if (exp_w_q.size() > 0) chk("wdata_wstrb", {wdata_o, wstrb_o}, exp_w_q.pop_front());
            else chk("w_unexpected", w_hs_p, 1'b0);
        end
        if (ar_hs_p) begin
            ar_hs_n++;
            if (exp_ar_q.size() > 0) chk("araddr", araddr_o, exp_ar_q.pop_front());
            else chk("ar_unexpected", ar_hs_p, 1'b0);
        end
        if (pull_p) begin
            pull_n++;
            chk("pull_nonempty", cmd_empty_i, 1'b0);
            pull_cyc = cyc;
            cur_we   = cmd_data_i[AW+36];
            txn_open = 1'b1;
        end
        if (push_p) begin
            push_n++;
            push_cyc = cyc;
            last_lat = cyc - pull_cyc;
            last_rsp = rsp_data_o;
            if (exp_rsp_q.size() > 0) chk("rsp_data", rsp_data_o, exp_rsp_q.pop_front());
            else chk("push_unexpected", push_p, 1'b0);
            txn_open = 1'b0;
        end
        prev_awv = awvalid_o & ~awready_i;  prev_awaddr = awaddr_o;
        prev_wv  = wvalid_o & ~wready_i;    prev_w      = {wdata_o, wstrb_o};
        prev_arv = arvalid_o & ~arready_i;  prev_araddr = araddr_o;
        prev_aw_hs = aw_hs_p;  prev_w_hs = w_hs_p;  prev_ar_hs = ar_hs_p;
    endtask

    task automatic clear_bfm();
        {aw_hs_p, w_hs_p, ar_hs_p, b_hs_p, r_hs_p, pull_p, push_p} = 7'd0;
        {prev_awv, prev_wv, prev_arv, prev_aw_hs, prev_w_hs, prev_ar_hs} = 6'd0;
        {slv_aw_done, slv_w_done, pend_b, pend_r, rsp_waiting, txn_open} = 6'd0;
        aw_cnt = 0;  w_cnt = 0;  ar_cnt = 0;  full_cnt = 0;
        awready_i = 1'b0;  wready_i = 1'b0;  arready_i = 1'b0;
        bvalid_i  = 1'b0;  rvalid_i = 1'b0;
    endtask

    task automatic drive();
        logic [33:0] head;
        if (pull_p) void'(cmd_q.pop_front());
        cmd_empty_i = (cmd_q.size() == 0);
        cmd_data_i  = (cmd_q.size() > 0) ? cmd_q[0] : '0;
        if (!areset_n_i) begin
            clear_bfm();
            return;
        end
        if (b_hs_p || r_hs_p) begin
            if (slv_q.size() > 0) void'(slv_q.pop_front());
            pend_b = pend_b & ~b_hs_p;
            pend_r = pend_r & ~r_hs_p;
        end
        if (aw_hs_p) slv_aw_done = 1'b1;
        if (w_hs_p)  slv_w_done  = 1'b1;
        if (slv_aw_done && slv_w_done) begin
            pend_b = 1'b1;  slv_aw_done = 1'b0;  slv_w_done = 1'b0;
        end
        if (ar_hs_p) pend_r = 1'b1;
        if (awvalid_o) begin awready_i = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin awready_i = 1'b0; aw_cnt = 0; end
        if (wvalid_o) begin wready_i = (w_cnt >= w_delay); w_cnt++; end
        else begin wready_i = 1'b0; w_cnt = 0; end
        if (arvalid_o) begin arready_i = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin arready_i = 1'b0; ar_cnt = 0; end
        head     = (slv_q.size() > 0) ? slv_q[0] : 34'd0;
        bvalid_i = pend_b;  bresp_i = head[1:0];
        rvalid_i = pend_r;  rresp_i = head[1:0];  rdata_i = head[33:2];
        if (b_hs_p || r_hs_p) begin
            rsp_waiting = 1'b1;  full_cnt = 0;
        end else if (full_mode && rsp_waiting && rsp_full_i) begin
            full_cnt++;
            if (full_cnt >= 5) begin rsp_full_i = 1'b0; fall_cyc = cyc; end
        end
        if (push_p) rsp_waiting = 1'b0;
    endtask

    // Bus functional model: observe at the falling edge, drive just after the rising edge
    initial begin
        forever begin
            @(negedge aclk_i);
            if (areset_n_i) monitor();
            else clear_bfm();
            @(posedge aclk_i);
            cyc++;
            #1;
            drive();
        end
    end

    task automatic wait_push(input int target, input string name);
        int n = 0;
        while (push_n < target && n < 300) begin
            @(negedge aclk_i);
            #1;
            n++;
        end
        chk({name, "_timeout"}, (push_n >= target), 1'b1);
    endtask

    task automatic settle(input int n);
        repeat (n) begin @(negedge aclk_i); #1; end
    endtask

    initial begin
        int p0, aw0, w0, ar0, pl0, n;
        areset_n_i = 1'b0;  rsp_full_i = 1'b0;  cmd_empty_i = 1'b1;  cmd_data_i = '0;
        awready_i = 1'b0;  wready_i = 1'b0;  arready_i = 1'b0;
        bvalid_i = 1'b0;  rvalid_i = 1'b0;  bresp_i = 2'b00;  rresp_i = 2'b00;  rdata_i = 32'h0;
        repeat (3) @(posedge aclk_i);
        #1;
        chk("rst_ctrl", {cmd_pull_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_push_o, busy_o}, 8'd0);
        chk("rst_data", {rsp_data_o, awaddr_o, araddr_o, wdata_o, wstrb_o}, 0);
        @(negedge aclk_i);  #2;  areset_n_i = 1'b1;

        // Write, AW accepted two cycles before W
        p0 = push_n;  aw0 = aw_hs_n;  w0 = w_hs_n;
        aw_delay = 0;  w_delay = 2;
        issue(1'b1, 28'h0000010, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0);
        wait_push(p0 + 1, "wr_slow_w");
        settle(5);
        chk("wr_rsp_literal", last_rsp, 35'h4_0000_0000);
        chk("wr_aw_count", aw_hs_n - aw0, 1);
        chk("wr_w_count", w_hs_n - w0, 1);
        chk("wr_push_count", push_n - p0, 1);

        // Read, AR accepted on the fourth valid cycle
        p0 = push_n;  w_delay = 0;  ar_delay = 3;  arv_cycles = 0;
        issue(1'b0, 28'h0000020, 32'h0, 4'h0, 2'b10, 32'h12345678);
        wait_push(p0 + 1, "rd_slow_ar");
        settle(5);
        chk("rd_rsp_literal", last_rsp, 35'h0_48D1_59E2);
        chk("rd_arvalid_cycles", arv_cycles, 4);
        chk("rd_push_count", push_n - p0, 1);

        // Zero-wait write, AW and W accepted together
        p0 = push_n;  aw0 = aw_hs_n;  w0 = w_hs_n;  ar_delay = 0;
        issue(1'b1, 28'h0000ABC, 32'h01234567, 4'h5, 2'b01, 32'h0);
        wait_push(p0 + 1, "wr_zero_wait");
        chk("wr_latency", last_lat, 4);
        chk("wr_sim_aw", aw_hs_n - aw0, 1);
        chk("wr_sim_w", w_hs_n - w0, 1);

        // Response FIFO full for five PUSH cycles, with a second command waiting
        p0 = push_n;  pl0 = pull_n;
        full_mode = 1'b1;  rsp_full_i = 1'b1;
        issue(1'b0, 28'h0000030, 32'h0, 4'h0, 2'b00, 32'h55AA55AA);
        issue(1'b1, 28'h0000034, 32'h89ABCDEF, 4'h9, 2'b00, 32'h0);
        wait_push(p0 + 1, "full_first");
        chk("full_push_after_fall", push_cyc - fall_cyc, 1);
        chk("full_pulls", pull_n - pl0, 1);
        full_mode = 1'b0;
        wait_push(p0 + 2, "full_second");
        rsp_full_i = 1'b0;

        // Three queued commands W, R, W
        p0 = push_n;  pl0 = pull_n;  aw0 = aw_hs_n;  ar0 = ar_hs_n;
        issue(1'b1, 28'h0000100, 32'h11112222, 4'h3, 2'b01, 32'h0);
        issue(1'b0, 28'h0FFFFFC, 32'h0, 4'h0, 2'b00, 32'hCAFEF00D);
        issue(1'b1, 28'hFFFFFFF, 32'hA5A5A5A5, 4'hC, 2'b11, 32'h0);
        wait_push(p0 + 3, "three_cmds");
        settle(3);
        chk("three_pulls", pull_n - pl0, 3);
        chk("three_aw", aw_hs_n - aw0, 2);
        chk("three_ar", ar_hs_n - ar0, 1);
        chk("three_last_rsp", last_rsp, {1'b1, 32'h0, 2'b11});

        // Reset while AW is stalled
        p0 = push_n;  aw_delay = 1000;
        issue(1'b1, 28'h0ABCDE0, 32'hFEEDC0DE, 4'hF, 2'b00, 32'h0);
        n = 0;
        while (!awvalid_o && n < 20) begin @(negedge aclk_i); #1; n++; end
        chk("rst_aw_seen", awvalid_o, 1'b1);
        @(negedge aclk_i);  #2;  areset_n_i = 1'b0;  #1;
        chk("rst_async_ctrl", {awvalid_o, wvalid_o, busy_o, rsp_push_o, cmd_pull_o}, 5'd0);
        chk("rst_async_data", {awaddr_o, wdata_o, rsp_data_o}, 0);
        exp_aw_q.delete();  exp_w_q.delete();  exp_rsp_q.delete();  slv_q.delete();
        aw_delay = 0;
        repeat (2) @(posedge aclk_i);
        @(negedge aclk_i);  #2;  areset_n_i = 1'b1;
        settle(6);
        chk("rst_no_push", push_n - p0, 0);
        issue(1'b0, 28'h0000044, 32'h0, 4'h0, 2'b01, 32'h0BADF00D);
        wait_push(p0 + 1, "after_rst");
        chk("after_rst_literal", last_rsp, 35'h0_2EB7_C035);

        settle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_mst.md
AXI4_LITE_MST -- requirements
Module: axi4_lite_mst

Interface
REQ-001 Parameter g_axi_addr_width, default 28, AXI address width (AW).
REQ-002 aclk_i  in  1  AXI clock; all logic on rising edge.
REQ-003 areset_n_i  in  1  reset, asynchronous, active-low.
REQ-004 cmd_empty_i  in  1  command FIFO empty (first-word fall-through).
REQ-005 cmd_data_i  in  AW+37  command {we[AW+36], addr[AW+35:36], wdata[35:4], wstrb[3:0]}; valid while cmd_empty_i low.
REQ-006 cmd_pull_o  out  1  one-cycle pulse, consumes one command word.
REQ-007 rsp_full_i  in  1  response FIFO full.
REQ-008 rsp_data_o  out  35  response {we[34], rdata[33:2], resp[1:0]}.
REQ-009 rsp_push_o  out  1  one-cycle pulse, writes rsp_data_o.
REQ-010 awvalid_o out 1, awready_i in 1, awaddr_o out AW, awprot_o out 3: AXI write address channel.
REQ-011 wvalid_o out 1, wready_i in 1, wdata_o out 32, wstrb_o out 4: AXI write data channel.
REQ-012 bvalid_i in 1, bready_o out 1, bresp_i in 2: AXI write response channel.
REQ-013 arvalid_o out 1, arready_i in 1, araddr_o out AW, arprot_o out 3: AXI read address channel.
REQ-014 rvalid_i in 1, rready_o out 1, rdata_i in 32, rresp_i in 2: AXI read data channel.
REQ-015 busy_o  out  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, FETCH, WR_REQ, WR_RESP, RD_REQ, RD_RESP, PUSH; one transaction outstanding at a time.
REQ-017 IDLE: cmd_empty_i low -> FETCH; otherwise stay.
REQ-018 FETCH (1 cycle): cmd_pull_o high; latch we, addr, wdata, wstrb into holding registers; we=1 -> WR_REQ, else RD_REQ.
REQ-019 awaddr_o, araddr_o, wdata_o, wstrb_o driven from holding registers; stable for the whole transaction.
REQ-020 awprot_o and arprot_o constant 3'b000.
REQ-021 WR_REQ entry: awvalid_o and wvalid_o both high in the same cycle.
REQ-022 awvalid_o deasserts the cycle after awvalid_o&awready_i; wvalid_o deasserts the cycle after wvalid_o&wready_i; each handshake is tracked independently (either order, or simultaneous).
REQ-023 A valid, once asserted, never deasserts before its handshake, and no addr/data change occurs while valid is high.
REQ-024 WR_REQ -> WR_RESP the cycle after both handshakes have completed.
REQ-025 WR_RESP: bready_o high; on bvalid_i&bready_o latch resp=bresp_i, rdata=0, we=1 -> PUSH; bready_o low from the next cycle.
REQ-026 RD_REQ: arvalid_o high until arvalid_o&arready_i; RD_REQ -> RD_RESP on that handshake.
REQ-027 RD_RESP: rready_o high; on rvalid_i&rready_o latch rdata=rdata_i, resp=rresp_i, we=0 -> PUSH.
REQ-028 PUSH: rsp_full_i low -> rsp_push_o high exactly one cycle, then IDLE; rsp_full_i high -> hold in PUSH, rsp_push_o low, no AXI activity.
REQ-029 rsp_data_o holds the last latched response until the next latch; it changes only on a B or R handshake.
REQ-030 bready_o and rready_o are low outside WR_RESP and RD_RESP; B/R beats arriving elsewhere are not accepted.
REQ-031 Zero-wait write (all readies high, FIFOs not empty or full): cmd_pull_o to rsp_push_o is 4 cycles; back-to-back commands start FETCH 1 cycle after PUSH.
REQ-032 Unreachable state codes return to IDLE on the next clock with all outputs low.

Reset
REQ-033 areset_n_i low immediately forces IDLE, and all valid, ready, pull, push and busy outputs low.
REQ-034 During reset, holding registers and rsp_data_o clear to 0; AXI addr/data outputs read 0.
REQ-035 Reset mid-transaction abandons it with no response push; the command already pulled is lost.

Verification
REQ-036 Write addr=0x0000010, wdata=0xDEADBEEF, wstrb=0xF; awready_i 2 cycles before wready_i; bresp=00 -> exactly one AW and one W handshake, rsp_data_o={1,0x00000000,00}, one push.
REQ-037 Read addr=0x0000020; arready_i delayed 3 cycles; rdata_i=0x12345678, rresp=10 -> rsp_data_o={0,0x12345678,10}, one push, arvalid_o high exactly 4 cycles.
REQ-038 rsp_full_i held high 5 cycles during PUSH -> no push and no new cmd_pull_o; push occurs the cycle after rsp_full_i falls.
REQ-039 Three queued commands W,R,W, all readies high -> three pulls, three pushes in order, with AW/W/AR values matching each command.
REQ-040 Reset asserted while awvalid_o is high, awready_i low -> awvalid_o low asynchronously, IDLE, no push; next command executes normally.
REQ-041 Simultaneous awready_i and wready_i in the first WR_REQ cycle -> both valids low the next cycle, WR_RESP entered with no extra handshake.
